// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - Reprogrammable delay store and seconds countdown timer for the anti-theft FSM
//
// Purpose:
//   Holds four 4-bit delay values (arm, driver door, passenger door, siren-on),
//   generates a free-running one-second enable tick, and counts a selected delay
//   down to zero, pulsing expired when it finishes.
//
// Ports:
//   clock           in   system clock
//   reset           in   synchronous, active-high reset
//   interval[1:0]   in   delay select for a load: 00 arm, 01 driver, 10 passenger, 11 alarm
//   start_timer     in   level; (re)loads the countdown on every edge it is high
//   reprogram       in   write time_value into slot time_param_sel
//   time_param_sel  in   slot to write, same encoding as interval
//   time_value[3:0] in   new delay in seconds
//   one_hz_enable   out  one-cycle pulse every ONE_HZ_DIV clocks
//   expired         out  one-cycle pulse when a countdown finishes
//   busy            out  high while counting
//   remaining[3:0]  out  seconds left in the current countdown
//
// Build option:
//   SYNC_DIVIDER_EN  when defined, the one-second divider is held cleared while
//                    start_timer is high so every counted second is full length.

module alarm_timer #(
    parameter int ONE_HZ_DIV   = 50000000,
    parameter int T_ARM_DEF    = 6,
    parameter int T_DRIVER_DEF = 8,
    parameter int T_PASS_DEF   = 15,
    parameter int T_ALARM_DEF  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] interval,
    input  logic       start_timer,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       one_hz_enable,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining
);

    localparam int DIV_W = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(ONE_HZ_DIV - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             one_hz_q, one_hz_d;
    logic             div_wrap;

    logic [3:0]       slot_q [4];

    logic [0:0]       state_q, state_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             expired_q, expired_d;

    // One-second divider
    always_comb begin
        div_wrap = (div_q == DIV_MAX);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        one_hz_d = div_wrap;
`ifdef SYNC_DIVIDER_EN
        // Holding the divider at zero during a load means the first tick lands
        // a full period after start_timer drops; a wrap coinciding with the
        // load is suppressed so it cannot shorten that first second.
        if (start_timer) begin
            div_d    = '0;
            one_hz_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q    <= '0;
            one_hz_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            one_hz_q <= one_hz_d;
        end
    end

    // Delay parameter slots. A load on the same edge as a write sees the old
    // value because both read slot_q before the nonblocking update lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q[0] <= 4'(T_ARM_DEF);
            slot_q[1] <= 4'(T_DRIVER_DEF);
            slot_q[2] <= 4'(T_PASS_DEF);
            slot_q[3] <= 4'(T_ALARM_DEF);
        end else if (reprogram) begin
            slot_q[time_param_sel] <= time_value;
        end
    end

    // Countdown. A load wins over everything, including an expiry that would
    // otherwise fire on this edge. The running count is a private copy, so
    // reprogramming a slot never disturbs it.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        if (start_timer) begin
            remaining_d = slot_q[interval];
            state_d     = S_COUNT;
        end else if (state_q == S_COUNT) begin
            if (remaining_q == 4'd0) begin
                expired_d = 1'b1;
                state_d   = S_IDLE;
            end else if (one_hz_q) begin
                remaining_d = remaining_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 4'd0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
        end
    end

    assign one_hz_enable = one_hz_q;
    assign expired       = expired_q;
    assign busy          = (state_q == S_COUNT);
    assign remaining     = remaining_q;

endmodule

// File: tb/tb_alarm_timer.sv
// tb/tb_alarm_timer.sv - Scoreboard bench for alarm_timer (ONE_HZ_DIV=4)
module tb_alarm_timer;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] interval;
    logic       start_timer;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       one_hz_enable;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;      // index of the latest clock edge since reset released
    int exp_q[$];        // expected edge index of each expired pulse

    alarm_timer #(
        .ONE_HZ_DIV  (4),
        .T_ARM_DEF   (6),
        .T_DRIVER_DEF(8),
        .T_PASS_DEF  (15),
        .T_ALARM_DEF (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .interval      (interval),
        .start_timer   (start_timer),
        .reprogram     (reprogram),
        .time_param_sel(time_param_sel),
        .time_value    (time_value),
        .one_hz_enable (one_hz_enable),
        .expired       (expired),
        .busy          (busy),
        .remaining     (remaining)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    // Edge at which expired is sampled high for a load of n at edge k.
    // Free-running: one_hz_enable is set on edges 4,8,12..., so decrements
    // happen on edges 5,9,13,...; expired follows the last decrement by one edge.
    function automatic int expiry_edge(int k, int n);
        if (n == 0) return k + 1;
`ifdef SYNC_DIVIDER_EN
        return k + 4 * n + 2;
`else
        begin
            int t;
            t = k + 1;
            while ((t % 4) != 1 || t < 5) t++;
            return t + 4 * (n - 1) + 1;
        end
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, ecnt);
        end
    endtask

    // Monitor: every expired pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && expired) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_expired actual=1 required=0 (edge %0d)", ecnt);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != ecnt) begin
                    errors++;
                    $display("FAIL expired_edge actual=%0d required=%0d", ecnt, e);
                end
            end
        end
    end

    task automatic do_start(input string name, input logic [1:0] iv, input int n,
                            input logic rp, input logic [1:0] sel, input logic [3:0] val);
        int k;
        @(negedge clock);
        interval       = iv;
        start_timer    = 1'b1;
        reprogram      = rp;
        time_param_sel = sel;
        time_value     = val;
        @(negedge clock);
        start_timer = 1'b0;
        reprogram   = 1'b0;
        k = ecnt;
        check({name, "_remaining"}, remaining, n);
        check({name, "_busy"}, busy, 1);
        exp_q.delete();
        exp_q.push_back(expiry_edge(k, n));
    endtask

    task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] val);
        @(negedge clock);
        reprogram      = 1'b1;
        time_param_sel = sel;
        time_value     = val;
        @(negedge clock);
        reprogram = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            check({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        check({name, "_busy_after"}, busy, 0);
        check({name, "_remaining_after"}, remaining, 0);
    endtask

    task automatic wait_remaining(input string name, input int v);
        int i;
        for (i = 0; i < 100 && remaining != 4'(v); i++) @(negedge clock);
        check({name, "_reached"}, remaining, v);
    endtask

    initial begin
        reset          = 1'b1;
        interval       = 2'b00;
        start_timer    = 1'b0;
        reprogram      = 1'b0;
        time_param_sel = 2'b00;
        time_value     = 4'd0;
        repeat (2) @(negedge clock);
        check("rst_expired", expired, 0);
        check("rst_busy", busy, 0);
        check("rst_remaining", remaining, 0);
        check("rst_one_hz", one_hz_enable, 0);
        reset = 1'b0;

        // 1: tick cadence, then default slot values via loads
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            check("one_hz_cadence", one_hz_enable, (ecnt >= 4 && ecnt % 4 == 0) ? 1 : 0);
        end
        do_start("slot_arm", 2'b00, 6, 1'b0, 2'b00, 4'd0);
        do_start("slot_pass", 2'b10, 15, 1'b0, 2'b00, 4'd0);
        do_start("slot_alarm", 2'b11, 10, 1'b0, 2'b00, 4'd0);

        // 2: driver delay runs to completion
        do_start("drv", 2'b01, 8, 1'b0, 2'b00, 4'd0);
        wait_done("drv");

        // 3: reprogrammed value, then write coinciding with load
        do_reprogram(2'b10, 4'd3);
        do_start("rp3", 2'b10, 3, 1'b0, 2'b00, 4'd0);
        wait_done("rp3");
        do_reprogram(2'b10, 4'd15);
        do_start("rp_same", 2'b10, 15, 1'b1, 2'b10, 4'd9);
        do_start("rp_new", 2'b10, 9, 1'b0, 2'b00, 4'd0);
        wait_done("rp_new");

        // 4: restart mid-count, no expiry between loads
        do_start("restart_a", 2'b00, 6, 1'b0, 2'b00, 4'd0);
        wait_remaining("restart_a", 2);
        do_start("restart_b", 2'b11, 10, 1'b0, 2'b00, 4'd0);
        wait_done("restart_b");

        // 5: zero delay expires one edge after the load
        do_reprogram(2'b11, 4'd0);
        do_start("zero", 2'b11, 0, 1'b0, 2'b00, 4'd0);
        wait_done("zero");

        // 6: reset mid-count aborts silently and restores slots
        do_start("abort", 2'b10, 9, 1'b0, 2'b00, 4'd0);
        wait_remaining("abort", 7);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_remaining", remaining, 0);
        check("abort_expired", expired, 0);
        repeat (20) @(negedge clock);
        do_start("post_reset", 2'b10, 15, 1'b0, 2'b00, 4'd0);
        wait_done("post_reset");
        do_start("post_reset_alarm", 2'b11, 10, 1'b0, 2'b00, 4'd0);
        wait_done("post_reset_alarm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_timer.md
Name: alarm_timer

Overview:
Time-parameter store and countdown timer serving the anti-theft control FSM's timer interface. It receives `interval` and `start_timer`, and returns `expired` and the free-running `one_hz_enable` tick. It holds four user-reprogrammable delay values, selected by the interval code. The FSM uses it for arming, door-entry and siren-on delays.

Parameters:
ONE_HZ_DIV, 50000000, clock cycles per one_hz_enable pulse (bench uses 4)
T_ARM_DEF, 6, reset value of arming delay (interval 00), seconds
T_DRIVER_DEF, 8, reset value of driver-door delay (interval 01), seconds
T_PASS_DEF, 15, reset value of passenger-door delay (interval 10), seconds
T_ALARM_DEF, 10, reset value of siren-on time (interval 11), seconds

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
interval  input  2  delay select from FSM: 00 arm, 01 driver, 10 passenger, 11 alarm
start_timer  input  1  level; load/reload countdown while high
reprogram  input  1  write time_value into parameter slot time_param_sel
time_param_sel  input  2  parameter slot to write, same encoding as interval
time_value  input  4  new delay in seconds, 0..15
one_hz_enable  output  1  one-cycle pulse every ONE_HZ_DIV clocks
expired  output  1  one-cycle pulse when countdown finishes
busy  output  1  high while countdown active (state COUNT)
remaining  output  4  seconds left in current countdown

Behaviour:
- Reset is synchronous and active-high; clock is clock. On reset: divider=0, one_hz_enable=0, expired=0, busy=0, remaining=0, state IDLE, param slots = T_*_DEF. Reset mid-count aborts silently (no expired).
- Divider: counter 0..ONE_HZ_DIV-1, free-running, wraps. one_hz_enable is registered and high exactly one cycle when the counter wraps. Widths use $clog2(ONE_HZ_DIV).
- Param regs: 4 x 4 bit. On an edge with reprogram=1, slot[time_param_sel] <= time_value.
  - A load in the same cycle reads the pre-write value.
  - Reprogram never alters a running countdown.
- Timer states: IDLE, COUNT.
  - Any state, start_timer=1 at edge: remaining <= slot[interval], state COUNT, expired <= 0. Start dominates every other event, including a pending expiry.
  - COUNT, start_timer=0, remaining==0: expired <= 1 for one cycle, state IDLE.
  - COUNT, start_timer=0, remaining>0, one_hz_enable=1: remaining <= remaining-1.
  - IDLE, start_timer=0: hold; expired <= 0.
- Latency: start held high through edge k with value N, released after. expired is high in the cycle following the edge where remaining hits 0 and is next sampled. For N=0, expired asserts at edge k+1.
- The first second may be partial (free-running divider) unless the optional feature is enabled.
- busy = (state==COUNT). remaining holds its last value in IDLE.
- interval changes while counting are ignored; the value is only sampled on a load.

Optional Feature:
SYNC_DIVIDER_EN
- Defined: divider counter is cleared on every edge with start_timer=1, so the first decrement occurs exactly ONE_HZ_DIV cycles after start_timer falls. Each second is full length.
- Undefined: divider is fully free-running; the first second is 1..ONE_HZ_DIV cycles.

Test Plan:
1. reset 2 cycles, ONE_HZ_DIV=4 -> expired=0, busy=0, remaining=0; one_hz_enable pulses every 4th cycle; reading slots via loads gives 6/8/15/10.
2. start_timer=1 one cycle, interval=01 -> remaining=8, busy=1; decrements on each one_hz pulse; expired single-cycle pulse after the 8th tick plus 1 cycle; busy=0 thereafter.
3. reprogram=1, sel=10, value=3, then start with interval=10 -> remaining=3, expired after 3 ticks. Repeat with reprogram and start in the same cycle -> old value 15 loaded.
4. Start interval 00; at remaining=2 pulse start with interval=11 -> remaining=10, no expired pulse between the two loads.
5. reprogram slot 11 to 0, start interval 11 -> expired high exactly one cycle, one cycle after start falls.
6. Start interval 10, assert reset at remaining=7 -> busy=0, remaining=0, no expired, slot 10 back to 15. With SYNC_DIVIDER_EN, the first decrement occurs exactly 4 cycles after start falls.
